// File: rtl/div_share_arb.sv
// div_share_arb
//   Shares one pipelined divider between N requesters. A round-robin arbiter
//   issues at most one division per cycle. A tag pipe carries {valid, id, dz}
//   alongside the divider's fixed latency. Each quotient/remainder pair is
//   steered into a small per-requester response FIFO.
//
// Ports
//   clk_i, rst_i      clock and synchronous active-high reset
//   req_valid_i[N]    requester k presents operands
//   req_ready_o[N]    one-hot or zero, requester k accepted this cycle
//   req_x_i           dividends, requester k at [k*(K+32) +: K+32]
//   req_d_i           divisors, requester k at [k*K +: K]
//   div_x_o, div_d_o  operands to the divider, zero when nothing is issued
//   div_q_i, div_r_i  divider results, valid LAT cycles after issue
//   rsp_valid_o[N]    response FIFO k non-empty
//   rsp_ready_i[N]    requester k pops its head entry
//   rsp_q_o, rsp_r_o  head quotient/remainder per requester, K bits each
//   rsp_dz_o[N]       head entry was issued with a zero divisor
module div_share_arb #(
  parameter int N         = 2,
  parameter int K         = 32,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        req_valid_i,
  output logic [N-1:0]        req_ready_o,
  input  logic [N*(K+32)-1:0] req_x_i,
  input  logic [N*K-1:0]      req_d_i,
  output logic [K+31:0]       div_x_o,
  output logic [K-1:0]        div_d_o,
  input  logic [K-1:0]        div_q_i,
  input  logic [K-1:0]        div_r_i,
  output logic [N-1:0]        rsp_valid_o,
  input  logic [N-1:0]        rsp_ready_i,
  output logic [N*K-1:0]      rsp_q_o,
  output logic [N*K-1:0]      rsp_r_o,
  output logic [N-1:0]        rsp_dz_o
);

  localparam int XW = K + 32;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // FIFO entry layout: {quotient, remainder, dz}
  localparam int EW = 2 * K + 1;

  logic [IW-1:0] rrPtr_q;
  logic [CW-1:0] inflight_q [N];
  logic [CW-1:0] inflight_d [N];
  logic [CW-1:0] count_q    [N];
  logic [CW-1:0] count_d    [N];
  logic [PW-1:0] wrPtr_q    [N];
  logic [PW-1:0] rdPtr_q    [N];
  logic [EW-1:0] mem_q      [N][RSP_DEPTH];
  logic [EW-1:0] lastHead_q [N];
  logic [EW-1:0] head       [N];

  logic          tagValid_q [LAT];
  logic [IW-1:0] tagId_q    [LAT];
  logic          tagDz_q    [LAT];

  logic [N-1:0]  eligible;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic          grantValid;
  logic [IW-1:0] grantId;
  logic [IW-1:0] scanIdx;
  logic          capValid;
  logic [IW-1:0] capId;
  logic [EW-1:0] capData;

  function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] p);
    bumpPtr = (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A requester may only issue if its FIFO is guaranteed room for the result:
  // results already in flight plus entries already queued must leave a free slot.
  // Start-of-cycle counts are used, so a pop this cycle frees credit next cycle.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < N; k++) begin
      eligible[k] = req_valid_i[k] &&
                    (({1'b0, inflight_q[k]} + {1'b0, count_q[k]}) < (CW + 1)'(RSP_DEPTH));
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    scanIdx    = '0;
    for (int i = 1; i <= N; i++) begin
      scanIdx = IW'((int'(rrPtr_q) + i) % N);
      if (!grantValid && !rst_i && eligible[scanIdx]) begin
        grantValid = 1'b1;
        grantId    = scanIdx;
      end
    end
  end

  // Drive the winner's operands to the divider; idle cycles drive zeros.
  always_comb begin
    req_ready_o = '0;
    div_x_o     = '0;
    div_d_o     = '0;
    if (grantValid) begin
      req_ready_o[grantId] = 1'b1;
      div_x_o = req_x_i[int'(grantId) * XW +: XW];
      div_d_o = req_d_i[int'(grantId) * K +: K];
    end
  end

  // The last tag stage lines up with the divider output of the same issue.
  assign capValid = tagValid_q[LAT-1];
  assign capId    = tagId_q[LAT-1];
  assign capData  = {div_q_i, div_r_i, tagDz_q[LAT-1]};

  // Response heads. An empty FIFO keeps showing whatever was popped last.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      head[k]             = (count_q[k] != '0) ? mem_q[k][rdPtr_q[k]] : lastHead_q[k];
      rsp_valid_o[k]      = (count_q[k] != '0);
      rsp_q_o[k*K +: K]   = head[k][EW-1 -: K];
      rsp_r_o[k*K +: K]   = head[k][K:1];
      rsp_dz_o[k]         = head[k][0];
    end
  end

  // Occupancy and in-flight credit bookkeeping; simultaneous inc/dec cancel.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < N; k++) begin
      push[k]       = capValid && (capId == IW'(k));
      pop[k]        = rsp_valid_o[k] && rsp_ready_i[k];
      count_d[k]    = count_q[k];
      inflight_d[k] = inflight_q[k];
      if (push[k] && !pop[k]) begin
        count_d[k] = count_q[k] + CW'(1);
      end else if (!push[k] && pop[k]) begin
        count_d[k] = count_q[k] - CW'(1);
      end
      if (req_ready_o[k] && !push[k]) begin
        inflight_d[k] = inflight_q[k] + CW'(1);
      end else if (!req_ready_o[k] && push[k]) begin
        inflight_d[k] = inflight_q[k] - CW'(1);
      end
    end
  end

  // Control state. Reset clears the tag pipe, so late divider outputs are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrPtr_q <= IW'(N - 1);
      for (int s = 0; s < LAT; s++) begin
        tagValid_q[s] <= 1'b0;
        tagId_q[s]    <= '0;
        tagDz_q[s]    <= 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        inflight_q[k] <= '0;
        count_q[k]    <= '0;
        wrPtr_q[k]    <= '0;
        rdPtr_q[k]    <= '0;
        lastHead_q[k] <= '0;
      end
    end else begin
      if (grantValid) begin
        rrPtr_q <= grantId;
      end
      tagValid_q[0] <= grantValid;
      tagId_q[0]    <= grantId;
      tagDz_q[0]    <= (div_d_o == '0);
      for (int s = 1; s < LAT; s++) begin
        tagValid_q[s] <= tagValid_q[s-1];
        tagId_q[s]    <= tagId_q[s-1];
        tagDz_q[s]    <= tagDz_q[s-1];
      end
      for (int k = 0; k < N; k++) begin
        inflight_q[k] <= inflight_d[k];
        count_q[k]    <= count_d[k];
        if (push[k]) begin
          wrPtr_q[k] <= bumpPtr(wrPtr_q[k]);
        end
        if (pop[k]) begin
          rdPtr_q[k]    <= bumpPtr(rdPtr_q[k]);
          lastHead_q[k] <= head[k];
        end
      end
    end
  end

  // FIFO storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk_i) begin
    if (capValid) begin
      mem_q[capId][wrPtr_q[capId]] <= capData;
    end
  end

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with N=2, K=32, LAT=2, RSP_DEPTH=2.
// A two-stage behavioural divider sits on the divider port. Inputs change
// 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_div_share_arb;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    reqValid;
  logic [1:0]    reqReady;
  logic [127:0]  reqX;
  logic [63:0]   reqD;
  logic [63:0]   divX;
  logic [31:0]   divD;
  logic [31:0]   divQ;
  logic [31:0]   divR;
  logic [1:0]    rspValid;
  logic [1:0]    rspReady;
  logic [63:0]   rspQ;
  logic [63:0]   rspR;
  logic [1:0]    rspDz;

  logic [63:0]   divS1;
  logic [63:0]   divS2;

  logic [64:0]   expQ0[$];
  logic [64:0]   expQ1[$];

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int cyc    = 0;
  int r0Grants = 0;
  int r1Grants = 0;
  int popsAtStart;
  logic got;

  always #5 clk = ~clk;

  div_share_arb #(.N(2), .K(32), .LAT(2), .RSP_DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_x_i     (reqX),
    .req_d_i     (reqD),
    .div_x_o     (divX),
    .div_d_o     (divD),
    .div_q_i     (divQ),
    .div_r_i     (divR),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_q_o     (rspQ),
    .rsp_r_o     (rspR),
    .rsp_dz_o    (rspDz)
  );

  // Behavioural divider: divide by zero returns all-ones quotient, low dividend bits as remainder.
  function automatic logic [63:0] divModel(input logic [63:0] x, input logic [31:0] d);
    logic [63:0] q64;
    logic [63:0] r64;
    if (d == 32'd0) begin
      divModel = {32'hFFFF_FFFF, x[31:0]};
    end else begin
      q64 = x / {32'd0, d};
      r64 = x % {32'd0, d};
      divModel = {q64[31:0], r64[31:0]};
    end
  endfunction

  function automatic logic [64:0] expEntry(input logic [63:0] x, input logic [31:0] d);
    expEntry = {divModel(x, d), (d == 32'd0)};
  endfunction

  // Two register stages: operands in cycle t appear on divQ/divR in cycle t+2.
  always @(posedge clk) begin
    divS1 <= divModel(divX, divD);
    divS2 <= divS1;
  end
  assign divQ = divS2[63:32];
  assign divR = divS2[31:0];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [63:0] x0, input logic [31:0] d0,
                               input logic [63:0] x1, input logic [31:0] d1, input logic [1:0] rr);
    reqValid = v;
    reqX     = {x1, x0};
    reqD     = {d1, d0};
    rspReady = rr;
  endtask

  // Falling-edge sample point; every pop is checked against the expected order.
  task automatic sample();
    @(negedge clk);
    if (rspValid[0] && rspReady[0]) begin
      checkOutput("rsp0_expected", 128'(expQ0.size() > 0), 128'(1));
      if (expQ0.size() > 0) begin
        checkOutput("rsp0_data", 128'({rspQ[31:0], rspR[31:0], rspDz[0]}), 128'(expQ0.pop_front()));
        pops++;
      end
    end
    if (rspValid[1] && rspReady[1]) begin
      checkOutput("rsp1_expected", 128'(expQ1.size() > 0), 128'(1));
      if (expQ1.size() > 0) begin
        checkOutput("rsp1_data", 128'({rspQ[63:32], rspR[63:32], rspDz[1]}), 128'(expQ1.pop_front()));
        pops++;
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    sample();
    checkOutput("rst_req_ready", 128'(reqReady), 128'(0));
    checkOutput("rst_rsp_valid", 128'(rspValid), 128'(0));
    checkOutput("rst_rsp_q", 128'(rspQ), 128'(0));
    checkOutput("rst_rsp_r", 128'(rspR), 128'(0));
    checkOutput("rst_rsp_dz", 128'(rspDz), 128'(0));
    checkOutput("rst_div_x", 128'(divX), 128'(0));
    checkOutput("rst_div_d", 128'(divD), 128'(0));
    nextCycle();
    rst = 1'b0;

    // Single request 100/7
    applyStimulus(2'b01, 64'd100, 32'd7, 64'd0, 32'd0, 2'b00);
    sample();
    checkOutput("t1_ready", 128'(reqReady), 128'(2'b01));
    checkOutput("t1_div_x", 128'(divX), 128'(100));
    checkOutput("t1_div_d", 128'(divD), 128'(7));
    expQ0.push_back({32'd14, 32'd2, 1'b0});
    nextCycle();
    applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00);
    sample();
    checkOutput("t1_idle_div_x", 128'(divX), 128'(0));
    checkOutput("t1_valid_c1", 128'(rspValid), 128'(0));
    nextCycle();
    sample();
    checkOutput("t1_valid_c2", 128'(rspValid), 128'(0));
    nextCycle();
    rspReady = 2'b01;
    sample();
    checkOutput("t1_valid_c3", 128'(rspValid), 128'(2'b01));
    checkOutput("t1_q", 128'(rspQ[31:0]), 128'(14));
    checkOutput("t1_r", 128'(rspR[31:0]), 128'(2));
    checkOutput("t1_dz", 128'(rspDz[0]), 128'(0));
    nextCycle();
    rspReady = 2'b00;
    sample();
    checkOutput("t1_empty_after_pop", 128'(rspValid), 128'(0));
    checkOutput("t1_head_hold", 128'(rspQ[31:0]), 128'(14));
    nextCycle();

    // Both requesting every cycle: strict alternation starting with r1
    popsAtStart = pops;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b11, 64'(1000 + i), 32'd10, 64'(500 + i), 32'd7, 2'b11);
      sample();
      checkOutput("t2_alternate", 128'(reqReady), 128'((i % 2 == 0) ? 2'b10 : 2'b01));
      if (i % 2 == 0) expQ1.push_back(expEntry(64'(500 + i), 32'd7));
      else            expQ0.push_back(expEntry(64'(1000 + i), 32'd10));
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b11);
      sample();
      nextCycle();
    end
    checkOutput("t2_all_delivered", 128'(pops - popsAtStart), 128'(8));
    checkOutput("t2_q0_drained", 128'(expQ0.size()), 128'(0));
    checkOutput("t2_q1_drained", 128'(expQ1.size()), 128'(0));

    // r1 back-pressured: only RSP_DEPTH grants, then one more after a pop
    popsAtStart = pops;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b10, 64'd0, 32'd0, 64'd60, 32'd7, 2'b00);
      sample();
      checkOutput("t3_credit", 128'(reqReady), 128'((i < 2) ? 2'b10 : 2'b00));
      if (i < 2) expQ1.push_back({32'd8, 32'd4, 1'b0});
      if (i == 4) checkOutput("t3_fifo_full", 128'(rspValid), 128'(2'b10));
      nextCycle();
    end
    applyStimulus(2'b10, 64'd0, 32'd0, 64'd60, 32'd7, 2'b10);
    sample();
    checkOutput("t3_pop_cycle_no_grant", 128'(reqReady), 128'(2'b00));
    nextCycle();
    applyStimulus(2'b10, 64'd0, 32'd0, 64'd60, 32'd7, 2'b00);
    sample();
    checkOutput("t3_grant_after_pop", 128'(reqReady), 128'(2'b10));
    expQ1.push_back({32'd8, 32'd4, 1'b0});
    nextCycle();
    applyStimulus(2'b10, 64'd0, 32'd0, 64'd60, 32'd7, 2'b00);
    sample();
    checkOutput("t3_full_again", 128'(reqReady), 128'(2'b00));
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b10);
      sample();
      nextCycle();
    end
    checkOutput("t3_delivered", 128'(pops - popsAtStart), 128'(3));
    checkOutput("t3_q1_drained", 128'(expQ1.size()), 128'(0));

    // Divide by zero followed by 5/3
    applyStimulus(2'b01, 64'd5, 32'd0, 64'd0, 32'd0, 2'b00);
    sample();
    checkOutput("t4_dz_accepted", 128'(reqReady), 128'(2'b01));
    expQ0.push_back(expEntry(64'd5, 32'd0));
    nextCycle();
    applyStimulus(2'b01, 64'd5, 32'd3, 64'd0, 32'd0, 2'b00);
    sample();
    checkOutput("t4_next_accepted", 128'(reqReady), 128'(2'b01));
    expQ0.push_back({32'd1, 32'd2, 1'b0});
    nextCycle();
    applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00);
    sample();
    nextCycle();
    sample();
    checkOutput("t4_valid_c3", 128'(rspValid), 128'(2'b01));
    checkOutput("t4_dz_c3", 128'(rspDz[0]), 128'(1));
    nextCycle();
    rspReady = 2'b01;
    sample();
    checkOutput("t4_dz_head", 128'(rspDz[0]), 128'(1));
    nextCycle();
    sample();
    checkOutput("t4_dz_clear", 128'(rspDz[0]), 128'(0));
    checkOutput("t4_q", 128'(rspQ[31:0]), 128'(1));
    checkOutput("t4_r", 128'(rspR[31:0]), 128'(2));
    nextCycle();
    rspReady = 2'b00;
    sample();
    checkOutput("t4_empty", 128'(rspValid), 128'(0));
    nextCycle();

    // Reset while two divisions are in flight
    applyStimulus(2'b11, 64'd40, 32'd3, 64'd50, 32'd4, 2'b00);
    sample();
    checkOutput("t5_grant_r1", 128'(reqReady), 128'(2'b10));
    nextCycle();
    sample();
    checkOutput("t5_grant_r0", 128'(reqReady), 128'(2'b01));
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00);
    sample();
    checkOutput("t5_no_grant_in_rst", 128'(reqReady), 128'(0));
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      checkOutput("t5_flushed", 128'(rspValid), 128'(0));
      nextCycle();
    end
    applyStimulus(2'b01, 64'd9, 32'd2, 64'd0, 32'd0, 2'b00);
    sample();
    checkOutput("t5_fresh_grant", 128'(reqReady), 128'(2'b01));
    expQ0.push_back({32'd4, 32'd1, 1'b0});
    nextCycle();
    applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00);
    sample();
    nextCycle();
    sample();
    nextCycle();
    rspReady = 2'b01;
    sample();
    checkOutput("t5_fresh_valid", 128'(rspValid), 128'(2'b01));
    checkOutput("t5_fresh_q", 128'(rspQ[31:0]), 128'(4));
    checkOutput("t5_fresh_r", 128'(rspR[31:0]), 128'(1));
    nextCycle();
    rspReady = 2'b00;

    // r0 always requesting, r1 in single-request bursts
    popsAtStart = pops;
    for (int b = 0; b < 14; b++) begin
      got = 1'b0;
      for (int w = 0; w < 3 && !got; w++) begin
        applyStimulus(2'b11, 64'(2000 + cyc), 32'd13, 64'(3000 + b), 32'd17, 2'b11);
        sample();
        checkOutput("t6_ready_legal", 128'({reqReady & ~reqValid, reqReady & (reqReady - 2'b01)}), 128'(0));
        if (reqReady[0]) begin
          expQ0.push_back(expEntry(64'(2000 + cyc), 32'd13));
          r0Grants++;
        end
        if (reqReady[1]) begin
          expQ1.push_back(expEntry(64'(3000 + b), 32'd17));
          r1Grants++;
          got = 1'b1;
        end else begin
          checkOutput("t6_r1_loses_once_to_r0", 128'({w == 0, reqReady}), 128'({1'b1, 2'b01}));
        end
        nextCycle();
        cyc++;
      end
      checkOutput("t6_r1_granted", 128'(got), 128'(1));
      for (int g = 0; g < 5; g++) begin
        applyStimulus(2'b01, 64'(2000 + cyc), 32'd13, 64'd0, 32'd0, 2'b11);
        sample();
        checkOutput("t6_ready_legal_gap", 128'({reqReady & ~reqValid, reqReady & (reqReady - 2'b01)}), 128'(0));
        if (reqReady[0]) begin
          expQ0.push_back(expEntry(64'(2000 + cyc), 32'd13));
          r0Grants++;
        end
        nextCycle();
        cyc++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b11);
      sample();
      nextCycle();
    end
    checkOutput("t6_r1_grants", 128'(r1Grants), 128'(14));
    checkOutput("t6_r0_not_starved", 128'(r0Grants >= 20), 128'(1));
    checkOutput("t6_delivered", 128'(pops - popsAtStart), 128'(r0Grants + r1Grants));
    checkOutput("t6_q0_drained", 128'(expQ0.size()), 128'(0));
    checkOutput("t6_q1_drained", 128'(expQ1.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
